// File: rtl/sr_latch_commander.sv
// Initiator for a remote set/reset latch: turns a req edge into SET/CLR strobes and checks Q/QN feedback.
// Latency: strobe or immediate done on the req capture edge; done on the first matching WAIT sample (+2 with SR_CMD_SYNC_EN).
// Backpressure: none; req edges while busy are dropped, retries on timeout, sticky err after MAX_RETRY re-drives.
module sr_latch_commander #(
  parameter int PULSE_LEN = 2,  // strobe high time per attempt, 1..15
  parameter int TIMEOUT   = 8,  // WAIT cycles allowed for feedback to match, 1..15
  parameter int MAX_RETRY = 3   // re-drive attempts after the first, 0..7
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN);
  localparam logic [3:0] WAIT_LAST  = 4'(TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);

  // Tile boundary unpacking.
  logic clk;
  logic rst_n;
  logic req_raw;
  logic level;
  logic fb_q_raw;
  logic fb_qn_raw;
  logic unused_io;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign req_raw   = io_in[2];
  assign level     = io_in[3];
  assign fb_q_raw  = io_in[4];
  assign fb_qn_raw = io_in[5];
  assign unused_io = ^io_in[7:6];

  // Inputs as seen by the control logic.
  logic req_use;
  logic fb_q;
  logic fb_qn;

`ifdef SR_CMD_SYNC_EN
  logic [1:0] req_sync;
  logic [1:0] fb_q_sync;
  logic [1:0] fb_qn_sync;

  // Two-flop synchronizers for the asynchronous request and feedback wires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync   <= 2'b00;
      fb_q_sync  <= 2'b00;
      fb_qn_sync <= 2'b00;
    end else begin
      req_sync   <= {req_sync[0], req_raw};
      fb_q_sync  <= {fb_q_sync[0], fb_q_raw};
      fb_qn_sync <= {fb_qn_sync[0], fb_qn_raw};
    end
  end

  assign req_use = req_sync[1];
  assign fb_q    = fb_q_sync[1];
  assign fb_qn   = fb_qn_sync[1];
`else
  assign req_use = req_raw;
  assign fb_q    = fb_q_raw;
  assign fb_qn   = fb_qn_raw;
`endif

  // Previous req sample for rising-edge detection.
  logic req_d;

  // Track req every cycle so an edge during a busy command is consumed, not deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d <= 1'b0;
    end else begin
      req_d <= req_use;
    end
  end

  logic req_edge;
  assign req_edge = req_use & ~req_d;

  // Target value latched at command start.
  logic lvl_r;

  // On the capture edge the latch has not been loaded yet, so compare against level directly.
  // Q == QN is never a valid latch state and always fails both compares.
  logic cap_match;
  logic wait_match;
  assign cap_match  = (fb_q == level) && (fb_qn == ~level);
  assign wait_match = (fb_q == lvl_r) && (fb_qn == ~lvl_r);

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] retries;
  logic       set_o;
  logic       clr_o;
  logic       busy;
  logic       done;
  logic       err;

  // Command FSM; every output is a flop so a low rst_n cuts a strobe without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      retries <= 3'd0;
      lvl_r   <= 1'b0;
      set_o   <= 1'b0;
      clr_o   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (req_edge) begin
            lvl_r   <= level;
            err     <= 1'b0;
            retries <= 3'd0;
            if (cap_match) begin
              // Latch already holds the target: confirm without strobing.
              done  <= 1'b1;
              cnt   <= 4'd0;
              state <= ST_IDLE;
            end else begin
              set_o <= level;
              clr_o <= ~level;
              busy  <= 1'b1;
              cnt   <= 4'd1;
              state <= ST_DRIVE;
            end
          end
        end

        ST_DRIVE: begin
          // cnt counts strobe cycles already elapsed including the current one.
          if (cnt == PULSE_LAST) begin
            set_o <= 1'b0;
            clr_o <= 1'b0;
            cnt   <= 4'd0;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_WAIT: begin
          if (wait_match) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            state <= ST_IDLE;
          end else if (cnt == WAIT_LAST) begin
            cnt <= 4'd0;
            if (retries < RETRY_MAX) begin
              // Re-strobe straight from the expiry edge.
              if (retries != 3'd7) begin
                retries <= retries + 3'd1;
              end
              set_o <= lvl_r;
              clr_o <= ~lvl_r;
              cnt   <= 4'd1;
              state <= ST_DRIVE;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_ERROR;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          set_o <= 1'b0;
          clr_o <= 1'b0;
          busy  <= 1'b0;
          cnt   <= 4'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_out = {retries, err, done, busy, clr_o, set_o};

  // Strobes are mutually exclusive and only present while driving.
  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst_n) !(set_o && clr_o));
  a_strobe_drive : assert property (@(posedge clk) disable iff (!rst_n)
                                    (set_o || clr_o) |-> (state == ST_DRIVE));
  // A command either confirms or fails, never both in one cycle.
  a_done_err : assert property (@(posedge clk) disable iff (!rst_n) !(done && err));

endmodule

// File: tb/tb_sr_latch_commander.sv
module tb_sr_latch_commander;

  localparam int P  = 2;
  localparam int T  = 8;
  localparam int M  = 3;
  localparam int NC = 48;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req   = 1'b0;
  logic       level = 1'b0;
  logic       fb_q  = 1'b0;
  logic       fb_qn = 1'b0;
  logic [1:0] spare = 2'b00;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int tests = 0;
  int fails = 0;

  assign io_in = {spare, fb_qn, fb_q, level, req, rst_n, clk};

  sr_latch_commander #(.PULSE_LEN(P), .TIMEOUT(T), .MAX_RETRY(M)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  // Per-edge stimulus for one command; index 0 is the req capture edge.
  logic req_a  [NC];
  logic lvl_a  [NC];
  logic fbq_a  [NC];
  logic fbqn_a [NC];

  // Results of the last run_cmd for scenario-specific checks.
  int         last_set_cycles;
  int         last_clr_cycles;
  int         last_done_cnt;
  int         last_done_t;
  logic [7:0] last_out;

  function automatic bit fb_ok(int t, logic lv);
    return (fbq_a[t] == lv) && (fbqn_a[t] == ~lv);
  endfunction

  function automatic logic [7:0] pack(int rt, bit e, bit d, bit b, bit c, bit s);
    return {3'(rt), e, d, b, c, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill stimulus with a single req pulse, random post-capture level, and feedback that
  // is a random mismatching pair before match_at and the correct pair from match_at on.
  task automatic fill_stim(input logic lv, input int req_w, input int match_at, input bit noise);
    int r;
    for (int t = 0; t < NC; t++) begin
      req_a[t] = (t < req_w);
      lvl_a[t] = (t == 0) ? lv : 1'($urandom_range(0, 1));
      if (noise) begin
        fbq_a[t]  = 1'($urandom_range(0, 1));
        fbqn_a[t] = 1'($urandom_range(0, 1));
      end else if (t >= match_at) begin
        fbq_a[t]  = lv;
        fbqn_a[t] = ~lv;
      end else begin
        r = $urandom_range(0, 2);
        fbq_a[t]  = (r == 0) ? ~lv : (r == 1) ? 1'b0 : 1'b1;
        fbqn_a[t] = (r == 0) ?  lv : (r == 1) ? 1'b0 : 1'b1;
      end
    end
  endtask

  // Build the expected output timeline from the attempt/window arithmetic, then drive and compare.
  task automatic run_cmd(input string name);
    logic [7:0] exp_o [NC];
    logic       lv;
    int         s, a, nxt;
    bit         fin;
    lv = lvl_a[0];
    for (int t = 0; t < NC; t++) exp_o[t] = 8'h00;
    if (fb_ok(0, lv)) begin
      exp_o[0] = pack(0, 0, 1, 0, 0, 0);
    end else begin
      s = 0; a = 0; fin = 0;
      while (!fin) begin
        // Attempt a: strobe for P edges, then a window of T sampled WAIT edges.
        for (int t = s; t < s + P; t++) exp_o[t] = pack(a, 0, 0, 1, ~lv, lv);
        exp_o[s + P] = pack(a, 0, 0, 1, 0, 0);
        nxt = -1;
        for (int e = s + P + 1; e <= s + P + T && !fin && nxt < 0; e++) begin
          if (fb_ok(e, lv)) begin
            exp_o[e] = pack(a, 0, 1, 0, 0, 0);
            for (int k = e + 1; k < NC; k++) exp_o[k] = pack(a, 0, 0, 0, 0, 0);
            fin = 1;
          end else if (e == s + P + T) begin
            if (a < M) nxt = e;
            else begin
              for (int k = e; k < NC; k++) exp_o[k] = pack(a, 1, 0, 0, 0, 0);
              fin = 1;
            end
          end else begin
            exp_o[e] = pack(a, 0, 0, 1, 0, 0);
          end
        end
        if (!fin) begin
          s = nxt;
          a++;
        end
      end
    end

    last_set_cycles = 0; last_clr_cycles = 0; last_done_cnt = 0; last_done_t = -1;
    for (int t = 0; t < NC; t++) begin
      req   = req_a[t];
      level = lvl_a[t];
      fb_q  = fbq_a[t];
      fb_qn = fbqn_a[t];
      spare = 2'($urandom_range(0, 3));
      tick();
      tests++;
      if (io_out !== exp_o[t]) begin
        fails++;
        $display("FAIL %s t=%0d io_out got %b expected %b", name, t, io_out, exp_o[t]);
      end
      if (io_out[0] === 1'b1) last_set_cycles++;
      if (io_out[1] === 1'b1) last_clr_cycles++;
      if (io_out[3] === 1'b1) begin
        last_done_cnt++;
        if (last_done_t < 0) last_done_t = t;
      end
      last_out = io_out;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; level = 1'b0; fb_q = 1'b0; fb_qn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (io_out !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold io_out got %b expected 00000000", io_out);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (io_out !== 8'h00) begin
        fails++;
        $display("FAIL reset_idle io_out got %b expected 00000000", io_out);
      end
    end
  endtask

  // Feedback follows set_o with one cycle of delay.
  task automatic test_set_follow();
    int  set_n, clr_n, done_n, done_t;
    bit  prev_set;
    logic [2:0] ret_at_done;
    set_n = 0; clr_n = 0; done_n = 0; done_t = -1; prev_set = 0; ret_at_done = 3'd7;
    level = 1'b1; fb_q = 1'b0; fb_qn = 1'b1; req = 1'b1;
    for (int t = 0; t < 14; t++) begin
      tick();
      if (io_out[0]) set_n++;
      if (io_out[1]) clr_n++;
      if (io_out[3]) begin
        done_n++;
        if (done_t < 0) begin done_t = t; ret_at_done = io_out[7:5]; end
      end
      if (prev_set) begin fb_q = 1'b1; fb_qn = 1'b0; end
      prev_set = io_out[0];
      if (t == 1) req = 1'b0;
    end
    tests++;
    if (set_n != P) begin fails++; $display("FAIL follow_set_cycles got %0d expected %0d", set_n, P); end
    tests++;
    if (clr_n != 0) begin fails++; $display("FAIL follow_clr_cycles got %0d expected 0", clr_n); end
    tests++;
    if (done_t != P + 1 || done_n != 1) begin
      fails++;
      $display("FAIL follow_done got t=%0d n=%0d expected t=%0d n=1", done_t, done_n, P + 1);
    end
    tests++;
    if (ret_at_done !== 3'd0) begin fails++; $display("FAIL follow_retries got %0d expected 0", ret_at_done); end
  endtask

  task automatic test_already_match();
    level = 1'b0; fb_q = 1'b0; fb_qn = 1'b1; req = 1'b1;
    tick();
    tests++;
    if (io_out !== 8'b000_0_1_0_0_0) begin
      fails++;
      $display("FAIL match_capture io_out got %b expected 00001000", io_out);
    end
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (io_out !== 8'h00) begin
        fails++;
        $display("FAIL match_quiet io_out got %b expected 00000000", io_out);
      end
    end
  endtask

  task automatic test_stuck(input bit both_high);
    fill_stim(1'b1, 2, 1000, 0);
    for (int t = 0; t < NC; t++) begin
      fbq_a[t]  = both_high;
      fbqn_a[t] = 1'b1;
    end
    run_cmd(both_high ? "stuck11" : "stuck01");
    tests++;
    if (last_set_cycles != (M + 1) * P) begin
      fails++;
      $display("FAIL stuck_set_cycles got %0d expected %0d", last_set_cycles, (M + 1) * P);
    end
    tests++;
    if (last_out !== {3'(M), 1'b1, 4'b0000}) begin
      fails++;
      $display("FAIL stuck_final io_out got %b expected %b", last_out, {3'(M), 1'b1, 4'b0000});
    end
  endtask

  task automatic test_reset_mid_pulse();
    level = 1'b1; fb_q = 1'b0; fb_qn = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tests++;
    if (io_out[0] !== 1'b1) begin fails++; $display("FAIL midrst_pre set_o got %b expected 1", io_out[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (io_out !== 8'h00) begin
      fails++;
      $display("FAIL midrst_async io_out got %b expected 00000000", io_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (io_out !== 8'h00) begin
      fails++;
      $display("FAIL midrst_after io_out got %b expected 00000000", io_out);
    end
    fill_stim(1'($urandom_range(0, 1)), 1, 6, 0);
    run_cmd("midrst_fresh");
  endtask

  task automatic test_back_to_back();
    logic lv;
    lv = 1'($urandom_range(0, 1));
    fill_stim(lv, 1, P + 3, 0);
    for (int t = 3; t < 8; t++) req_a[t] = 1'b1;
    run_cmd("retrigger");
    tests++;
    if (last_done_cnt != 1 || last_done_t != P + 3) begin
      fails++;
      $display("FAIL retrigger_done got n=%0d t=%0d expected n=1 t=%0d", last_done_cnt, last_done_t, P + 3);
    end
    tests++;
    if (last_out[7:5] !== 3'd0) begin
      fails++;
      $display("FAIL retrigger_retries got %0d expected 0", last_out[7:5]);
    end
  endtask

  task automatic test_random();
    int ma;
    int sel;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       ma = 0;
        1:       ma = 1000;
        2:       ma = $urandom_range(1, 12);
        default: ma = $urandom_range(1, 42);
      endcase
      fill_stim(1'($urandom_range(0, 1)), $urandom_range(1, 3), ma, (sel == 5));
      run_cmd("random");
    end
  endtask

  initial begin
    test_reset();
    test_set_follow();
    test_already_match();
    test_stuck(1'b0);
    test_stuck(1'b1);
    test_reset_mid_pulse();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
